hyperbus_cfg_apb_bridge: RTL
============================

HYPERBUS_CFG_APB_BRIDGE -- requirements
Module: hyperbus_cfg_apb_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 256, meaning cfg_ready_i wait limit in clk_sys_i cycles (legal range 2..65535).
REQ-002 clk_sys_i  input  1  system clock; all logic rising-edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 apb_paddr_i  input  32  APB address.
REQ-005 apb_psel_i  input  1  APB select.
REQ-006 apb_penable_i  input  1  APB access phase.
REQ-007 apb_pwrite_i  input  1  1 = write, 0 = read.
REQ-008 apb_pwdata_i  input  32  APB write data.
REQ-009 apb_pstrb_i  input  4  APB byte strobes.
REQ-010 apb_prdata_o  output  32  APB read data.
REQ-011 apb_pready_o  output  1  APB transfer complete.
REQ-012 apb_pslverr_o  output  1  APB error, valid with pready.
REQ-013 cfg_addr_o  output  32  config request address.
REQ-014 cfg_write_o  output  1  config request direction.
REQ-015 cfg_wdata_o  output  32  config write data.
REQ-016 cfg_wstrb_o  output  4  config byte strobes.
REQ-017 cfg_valid_o  output  1  config request valid.
REQ-018 cfg_rdata_i  input  32  config read data, sampled with cfg_ready_i.
REQ-019 cfg_error_i  input  1  config error, sampled with cfg_ready_i.
REQ-020 cfg_ready_i  input  1  config request accepted and completed this cycle.

Function
REQ-021 FSM states: IDLE, REQ, DONE; encoding free.
REQ-022 IDLE: on apb_psel_i=1 and apb_penable_i=1, register request fields and enter REQ next cycle; otherwise stay.
REQ-023 Captured fields: cfg_addr_o = {paddr[31:2],2'b00}; cfg_write_o = pwrite; cfg_wdata_o = pwdata; cfg_wstrb_o = pstrb on write, 4'h0 on read.
REQ-024 cfg_valid_o is 1 exactly while in REQ; cfg_* request fields stay stable throughout REQ.
REQ-025 REQ: on cfg_ready_i=1, register cfg_rdata_i (reads only, else 0) into apb_prdata_o and cfg_error_i into apb_pslverr_o, then enter DONE.
REQ-026 Timeout counter: cleared on REQ entry, increments each REQ cycle with cfg_ready_i=0; when TIMEOUT cycles have elapsed without ready, enter DONE with apb_pslverr_o=1, apb_prdata_o=32'h0.
REQ-027 cfg_ready_i=1 in the same cycle the timeout limit is reached: ready wins, no timeout error.
REQ-028 DONE: apb_pready_o=1 for exactly one cycle, then IDLE; apb_pready_o is 0 in all other states.
REQ-029 apb_prdata_o and apb_pslverr_o hold their value until the next completion.
REQ-030 Minimum latency: access-phase cycle T0 -> cfg_valid_o at T1 -> cfg_ready_i at T1 -> apb_pready_o at T2.
REQ-031 apb_psel_i deasserted during REQ: transaction continues to completion; DONE pulse issued regardless.
REQ-032 cfg_ready_i, cfg_error_i, cfg_rdata_i outside REQ are ignored.
REQ-033 At most one outstanding cfg request; no new capture until return to IDLE.

Reset
REQ-034 rst_i=1 at a rising edge forces IDLE, counter 0, cfg_valid_o=0, apb_pready_o=0, apb_pslverr_o=0, apb_prdata_o=0, all cfg_* request outputs 0.
REQ-035 Reset during REQ or DONE abandons the transaction; no pready pulse is generated afterwards for it.

Verification
REQ-036 APB write addr 32'h0000_0013, data 32'hA5A5_5A5A, strb 4'hF, cfg_ready_i at first REQ cycle -> cfg_addr_o=32'h0000_0010, cfg_wstrb_o=4'hF, one-cycle cfg_valid_o, apb_pready_o 2 cycles after access phase, pslverr=0.
REQ-037 APB read, cfg_ready_i after 5 cycles with cfg_rdata_i=32'h1234_5678, cfg_error_i=1 -> cfg_wstrb_o=4'h0, apb_prdata_o=32'h1234_5678, apb_pslverr_o=1 with pready.
REQ-038 TIMEOUT=4, cfg_ready_i held 0 -> cfg_valid_o high exactly 4 cycles, then apb_pready_o=1, apb_pslverr_o=1, apb_prdata_o=0.
REQ-039 TIMEOUT=4, cfg_ready_i=1 on 4th REQ cycle with rdata 32'hCAFE_0001 -> no error, apb_prdata_o=32'hCAFE_0001.
REQ-040 rst_i pulsed on 2nd REQ cycle -> cfg_valid_o=0 next cycle, no apb_pready_o pulse; subsequent read completes normally.
REQ-041 apb_psel_i dropped mid-REQ, then cfg_ready_i -> single apb_pready_o pulse, FSM returns to IDLE, stray cfg_ready_i in IDLE ignored.

Source files
------------

// File: rtl/hyperbus_cfg_apb_bridge.sv
// APB slave to single-outstanding config request bridge.
// One APB access becomes one cfg request; a bounded wait on cfg_ready_i ends in an error completion.
module hyperbus_cfg_apb_bridge #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk_sys_i,
   input  logic        rst_i,
   input  logic [31:0] apb_paddr_i,
   input  logic        apb_psel_i,
   input  logic        apb_penable_i,
   input  logic        apb_pwrite_i,
   input  logic [31:0] apb_pwdata_i,
   input  logic [3:0]  apb_pstrb_i,
   output logic [31:0] apb_prdata_o,
   output logic        apb_pready_o,
   output logic        apb_pslverr_o,
   output logic [31:0] cfg_addr_o,
   output logic        cfg_write_o,
   output logic [31:0] cfg_wdata_o,
   output logic [3:0]  cfg_wstrb_o,
   output logic        cfg_valid_o,
   input  logic [31:0] cfg_rdata_i,
   input  logic        cfg_error_i,
   input  logic        cfg_ready_i
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
   logic [31:0]      r_addr,    w_addr_nxt;
   logic             r_write,   w_write_nxt;
   logic [31:0]      r_wdata,   w_wdata_nxt;
   logic [3:0]       r_wstrb,   w_wstrb_nxt;
   logic             r_valid,   w_valid_nxt;
   logic [31:0]      r_prdata,  w_prdata_nxt;
   logic             r_pslverr, w_pslverr_nxt;
   logic             r_pready,  w_pready_nxt;
   logic             w_unused;

   // Word-aligned requests only; the byte offset bits are dropped.
   assign w_unused = ^apb_paddr_i[1:0];

   // State and datapath registers.
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_valid   <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
         r_pready  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_addr    <= w_addr_nxt;
         r_write   <= w_write_nxt;
         r_wdata   <= w_wdata_nxt;
         r_wstrb   <= w_wstrb_nxt;
         r_valid   <= w_valid_nxt;
         r_prdata  <= w_prdata_nxt;
         r_pslverr <= w_pslverr_nxt;
         r_pready  <= w_pready_nxt;
      end
   end

   // Next-state, capture and completion logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_addr_nxt    = r_addr;
      w_write_nxt   = r_write;
      w_wdata_nxt   = r_wdata;
      w_wstrb_nxt   = r_wstrb;
      w_prdata_nxt  = r_prdata;
      w_pslverr_nxt = r_pslverr;

      case (r_state)
         S_IDLE: begin
            if (apb_psel_i && apb_penable_i) begin
               w_addr_nxt  = {apb_paddr_i[31:2], 2'b00};
               w_write_nxt = apb_pwrite_i;
               w_wdata_nxt = apb_pwdata_i;
               w_wstrb_nxt = apb_pwrite_i ? apb_pstrb_i : 4'h0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // A ready arriving on the final allowed cycle still completes cleanly.
            if (cfg_ready_i) begin
               w_prdata_nxt  = r_write ? 32'h0 : cfg_rdata_i;
               w_pslverr_nxt = cfg_error_i;
               w_state_nxt   = S_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_prdata_nxt  = 32'h0;
               w_pslverr_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_valid_nxt  = (w_state_nxt == S_REQ);
      w_pready_nxt = (w_state_nxt == S_DONE);
   end

   assign apb_prdata_o  = r_prdata;
   assign apb_pready_o  = r_pready;
   assign apb_pslverr_o = r_pslverr;
   assign cfg_addr_o    = r_addr;
   assign cfg_write_o   = r_write;
   assign cfg_wdata_o   = r_wdata;
   assign cfg_wstrb_o   = r_wstrb;
   assign cfg_valid_o   = r_valid;

endmodule
